// File: rtl/cpu_dbg_pkg.sv
// Shared constants and types for the CPU debug register read-out path.
// State encodings are plain 3-bit constants so they match debug probes one-to-one.
package cpu_dbg_pkg;

  localparam int REG_NUM_W = 5;
  localparam int DATA_W    = 32;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_SEND = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  typedef struct packed {
    logic [REG_NUM_W-1:0] idx;
    logic [DATA_W-1:0]    data;
  } dump_word_t;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Register-file debug read port plus the valid/ready word stream toward the host.
// The master side is the dump reader; the slave side is the regfile and consumer.
interface reg_dump_reader_if;
  import cpu_dbg_pkg::*;

  logic [REG_NUM_W-1:0] rnum;
  logic [DATA_W-1:0]    rdata;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data;
  logic [REG_NUM_W-1:0] out_idx;

  modport master (
    output rnum,
    input  rdata,
    output out_valid,
    output out_data,
    output out_idx,
    input  out_ready
  );

  modport slave (
    input  rnum,
    output rdata,
    input  out_valid,
    input  out_data,
    input  out_idx,
    output out_ready
  );

endinterface

// File: rtl/reg_dump_outbuf.sv
// One-entry output holding register: loads a tagged word on capture, presents it
// until the consumer accepts it; flush drops the word without delivering it.
module reg_dump_outbuf
  import cpu_dbg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       capture,
  input  logic       flush,
  input  dump_word_t cap_word,
  input  logic       ready,
  output logic       valid,
  output dump_word_t word,
  output logic       fire
);

  logic       valid_reg;
  dump_word_t word_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      word_reg  <= '0;
    end else begin
      if (flush)
        valid_reg <= 1'b0;
      else if (capture)
        valid_reg <= 1'b1;
      else if (fire)
        valid_reg <= 1'b0;
      // The word itself persists after delivery so the host can still read it in IDLE.
      if (capture)
        word_reg <= cap_word;
    end
  end

  assign fire  = valid_reg && ready;
  assign valid = valid_reg;
  assign word  = word_reg;

endmodule

// File: rtl/reg_dump_reader.sv
// Walks FIRST_REG..LAST_REG on the register file debug port and streams each
// captured word, tagged with its index, out through a one-entry buffer.
module reg_dump_reader
  import cpu_dbg_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31,
  parameter int RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  reg_dump_reader_if.master  bus,
  output logic               busy,
  output logic               done
);

  localparam logic [REG_NUM_W-1:0] FIRST_NUM = REG_NUM_W'(FIRST_REG);
  localparam logic [REG_NUM_W-1:0] LAST_NUM  = REG_NUM_W'(LAST_REG);

  logic [2:0]           state_reg;
  logic [2:0]           state_next;
  logic [REG_NUM_W-1:0] cnt_reg;
  logic [REG_NUM_W-1:0] cnt_next;
  logic                 capture;
  logic                 flush;
  logic                 fire;
  logic                 out_valid;
  dump_word_t           cap_word;
  dump_word_t           out_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= FIRST_NUM;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The counter snaps back to FIRST_REG on leaving a dump so rnum idles there.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_ADDR;
          cnt_next   = FIRST_NUM;
        end
      end
      ST_ADDR: state_next = (RD_LAT == 0) ? ST_SEND : ST_WAIT;
      ST_WAIT: state_next = ST_SEND;
      ST_SEND: begin
        if (fire) begin
          if (cnt_reg == LAST_NUM) begin
            state_next = ST_FIN;
            cnt_next   = FIRST_NUM;
          end else begin
            state_next = ST_ADDR;
            cnt_next   = cnt_reg + 1'b1;
          end
        end
      end
      ST_FIN: state_next = ST_IDLE;
      default: begin
        state_next = ST_IDLE;
        cnt_next   = FIRST_NUM;
      end
    endcase
    if (abort && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
      cnt_next   = FIRST_NUM;
    end
  end

  // An aborted read is never captured, so no partial word can surface later.
  always_comb begin
    busy    = (state_reg != ST_IDLE);
    done    = (state_reg == ST_FIN);
    flush   = abort && (state_reg != ST_IDLE);
    capture = !abort &&
              (((state_reg == ST_ADDR) && (RD_LAT == 0)) || (state_reg == ST_WAIT));
  end

  assign cap_word = '{idx: cnt_reg, data: bus.rdata};

  reg_dump_outbuf u_outbuf (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture),
    .flush    (flush),
    .cap_word (cap_word),
    .ready    (bus.out_ready),
    .valid    (out_valid),
    .word     (out_word),
    .fire     (fire)
  );

  assign bus.rnum      = cnt_reg;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_word.data;
  assign bus.out_idx   = out_word.idx;

endmodule
